bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter that runs the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It owns a bank of per-digit add-3 correctors and sequences them: it loads a binary operand on a start handshake, iterates W adjust/shift steps, then presents the packed BCD result with a one-cycle done pulse. It sits between binary datapath results and display/BCD consumers.

## Interface
- W, default 8: binary operand width, legal range 4..16.
- DIGITS, default 3: number of BCD output digits. Must satisfy DIGITS >= ceil(W*log10(2)); no overflow detection.
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  request; sampled only while in IDLE.
- bin  in  W  operand; captured on the accepted start edge; ignored otherwise.
- busy  out  1  high whenever state != IDLE.
- done  out  1  single-cycle pulse; result valid.
- bcd  out  4*DIGITS  packed result, digit k in bits [4k+3:4k], k=0 is units.

## Operation
- Internal registers:
  - scratch shift register {digits[4*DIGITS-1:0], bits[W-1:0]}.
  - iteration counter cnt, width clog2(W+1).
  - 2-bit state.
  - registered bcd.
- FSM states:
  - IDLE: if start=1, load bits<=bin, digits<=0, cnt<=0, go to CONV. Otherwise hold.
  - CONV: one iteration per cycle.
    - Adjust: each 4-bit digit d becomes d>=5 ? d+3 : d. The adder is 4-bit; no carry leaves the digit, and none is possible because d<=9 before adjusting.
    - Shift: the whole scratch register shifts left by 1; the MSB of bits enters the LSB of digit 0.
    - cnt<=cnt+1. When cnt==W-1, this is the last iteration: write bcd<=shifted digits and go to DONE.
  - DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- bcd holds its value from the DONE cycle until the next DONE. It does not change when a new start is accepted or during CONV.
- A start in CONV or DONE is ignored, not queued. If start is held high continuously, a new conversion is accepted in the IDLE cycle that follows DONE.
- Values of bin outside the capture edge do not affect the result.
- Reset (rst_n=0 at a clock edge) forces state=IDLE, busy=0, done=0, bcd=0, cnt=0, scratch=0. A reset in CONV or DONE aborts the conversion with no done pulse and takes priority over start.

## Timing
- Reset values: busy=0, done=0, bcd=0.
- Let edge 0 be the edge on which start is sampled high in IDLE.
  - busy rises after edge 0.
  - CONV occupies the cycles after edges 0..W-1.
  - The DONE cycle follows edge W: done=1, busy=1, and bcd is already valid.
  - busy and done fall after edge W+1.
- Latency from accepting start to done is W+1 cycles. Minimum accepted-start spacing is W+2 cycles.
- busy and done are registered outputs, with no combinational path from start or bin.
- Throughput with W=8 is one conversion per 10 cycles.

## Test plan
- Reset, then bin=8'd255 with start for 1 cycle -> done pulses exactly 9 cycles after the start edge, bcd=12'h255, busy high for 9 cycles.
- bin=0 -> bcd=12'h000. bin=8'd99 -> 12'h099. bin=8'd100 -> 12'h100. bin=8'd9 -> 12'h009. bcd stays stable until the next done.
- Start pulse for bin=8'd37, then start=1 with bin=8'd200 on the 3rd cycle of CONV -> the second request is ignored. A single done with bcd=12'h037, then IDLE.
- start held at 1 with bin=8'd128 -> done every 10 cycles, bcd=12'h128 each time, and busy low for exactly 1 cycle between runs.
- Start bin=8'd250, then rst_n=0 on the 4th CONV cycle -> no done pulse. The next cycle shows busy=0 and bcd=0. A new start with bin=8'd7 yields bcd=12'h007.
- Exhaustive sweep of bin over 0..255 (plus a W=10, DIGITS=4 build over 0..1023) -> every result matches the reference decimal digits, and done occurs exactly once per accepted start.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock
module bin2bcd_seq #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [W-1:0]          i_bin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd
);
    localparam int CW = $clog2(W + 1);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic [4*DIGITS-1:0]     r_digits;
    logic [W-1:0]            r_bits;
    logic [4*DIGITS-1:0]     w_adj;
    logic [4*DIGITS+W-1:0]   w_shift;
    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        assign w_adj[4*k+:4] = (r_digits[4*k+:4] >= 4'd5) ? r_digits[4*k+:4] + 4'd3 : r_digits[4*k+:4];
    end
    assign w_shift = {w_adj[4*DIGITS-2:0], r_bits, 1'b0};
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_digits <= '0;
            r_bits   <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_bcd    <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_start) begin
                    r_bits   <= i_bin;
                    r_digits <= '0;
                    r_cnt    <= '0;
                    o_busy   <= 1'b1;
                    r_state  <= CONV;
                end
                CONV: begin
                    {r_digits, r_bits} <= w_shift;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(W - 1)) begin
                        o_bcd   <= w_shift[4*DIGITS+W-1:W];
                        o_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq (W=8/DIGITS=3 and W=10/DIGITS=4 builds)
module tb_bin2bcd_seq;
    localparam int W = 8;
    localparam int D = 3;
    localparam int W2 = 10;
    localparam int D2 = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [W-1:0] bin = '0;
    logic busy, done;
    logic [4*D-1:0] bcd;
    logic start2 = 1'b0;
    logic [W2-1:0] bin2 = '0;
    logic busy2, done2;
    logic [4*D2-1:0] bcd2;
    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int accepts = 0;
    logic [63:0] q[$];
    logic [63:0] q2[$];
    always #5 clk = ~clk;
    bin2bcd_seq #(.W(W), .DIGITS(D)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_bin(bin),
        .o_busy(busy), .o_done(done), .o_bcd(bcd)
    );
    bin2bcd_seq #(.W(W2), .DIGITS(D2)) u_dut10 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_bin(bin2),
        .o_busy(busy2), .o_done(done2), .o_bcd(bcd2)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [63:0] ref_bcd(input int v, input int nd);
        logic [63:0] r = '0;
        int x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i+:4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction
    initial forever begin
        @(posedge clk);
        #1;
        if (done) begin
            done_cnt++;
            if (q.size() == 0) chk("unexpected_done", 64'(bcd), 64'hdead);
            else chk("bcd", 64'(bcd), q.pop_front());
        end
    end
    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(tag, 64'(busy), 64'd0);
    endtask
    task automatic run_one(input int v);
        @(negedge clk);
        start = 1'b1;
        bin = W'(v);
        q.push_back(ref_bcd(v, D));
        accepts++;
        @(negedge clk);
        start = 1'b0;
        bin = W'($urandom);
        wait_idle("idle_timeout");
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int busy_n, done_edge, done_n, d0, bad, nlow;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bcd", 64'(bcd), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        // 255: latency and busy width
        start = 1'b1;
        bin = 8'd255;
        q.push_back(ref_bcd(255, D));
        accepts++;
        busy_n = 0; done_edge = -1; done_n = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                start = 1'b0;
                bin = 8'd3;
            end
            if (busy) busy_n++;
            if (done) begin
                done_edge = k;
                done_n++;
            end
        end
        chk("busy_cycles", 64'(busy_n), 64'(W + 1));
        chk("done_edge", 64'(done_edge), 64'(W));
        chk("done_once", 64'(done_n), 64'd1);
        chk("bcd_255", 64'(bcd), 64'h255);
        run_one(0);
        run_one(99);
        run_one(100);
        run_one(9);
        repeat (5) @(negedge clk);
        chk("hold_9", 64'(bcd), 64'h009);
        // 37 with a second start during CONV that must be dropped
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        bin = 8'd37;
        q.push_back(ref_bcd(37, D));
        accepts++;
        @(negedge clk);
        start = 1'b0;
        chk("bcd_hold_conv", 64'(bcd), 64'h009);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        bin = 8'd200;
        @(negedge clk);
        start = 1'b0;
        chk("busy_conv", 64'(busy), 64'd1);
        wait_idle("idle_timeout_37");
        repeat (W + 4) @(negedge clk);
        chk("single_done_37", 64'(done_cnt - d0), 64'd1);
        chk("idle_after_37", 64'(busy), 64'd0);
        chk("bcd_37", 64'(bcd), 64'h037);
        // start held high: back-to-back conversions
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        bin = 8'd128;
        for (int i = 0; i < 3; i++) begin
            q.push_back(ref_bcd(128, D));
            accepts++;
        end
        bad = 0; nlow = 0; done_n = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                nlow++;
                if (k % 10 != 9) bad++;
            end
            if (done) begin
                done_n++;
                if (k % 10 != 8) bad++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("held_pattern", 64'(bad), 64'd0);
        chk("held_dones", 64'(done_n), 64'd3);
        chk("held_idle_cycles", 64'(nlow), 64'd3);
        wait_idle("idle_timeout_held");
        // reset mid-conversion aborts without done
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        bin = 8'd250;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_bcd", 64'(bcd), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        run_one(7);
        chk("bcd_7", 64'(bcd), 64'h007);
        for (int v = 0; v < 256; v++) run_one(v);
        chk("done_count", 64'(done_cnt), 64'(accepts));
        chk("queue_empty", 64'(q.size()), 64'd0);
        // W=10, DIGITS=4 build
        for (int v = 0; v < 1024; v++) begin
            bit seen = 1'b0;
            @(negedge clk);
            start2 = 1'b1;
            bin2 = W2'(v);
            q2.push_back(ref_bcd(v, D2));
            @(negedge clk);
            start2 = 1'b0;
            bin2 = W2'($urandom);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done2) begin
                    seen = 1'b1;
                    chk("bcd10", 64'(bcd2), q2.pop_front());
                    break;
                end
            end
            if (!seen) begin
                chk("done10_timeout", 64'd0, 64'd1);
                void'(q2.pop_front());
            end
        end
        chk("queue10_empty", 64'(q2.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
